// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky
// overflow/underflow errors and an optional first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              wr_acc;
  logic              rd_acc;

  // DEPTH need not be a power of two, so wrap is an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flags depend only on the registered count.
  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= CW'(AF_THRESH));
  assign almost_empty = (count_reg <= CW'(AE_THRESH));
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (rd_acc) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({wr_acc, rd_acc})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow_reg  <= (overflow_reg  && !clr_err) || (wr_en && full);
      underflow_reg <= (underflow_reg && !clr_err) || (rd_en && empty);
    end
  end

  // Storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_reg] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is always presented; masked to zero while empty.
      assign rd_data  = empty ? '0 : mem[rd_ptr_reg];
      assign rd_valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_reg;
      logic              rd_valid_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_acc;
          if (rd_acc) rd_data_reg <= mem[rd_ptr_reg];
        end
      end

      assign rd_data  = rd_data_reg;
      assign rd_valid = rd_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a default FIFO (DEPTH=16, registered read) and a DEPTH=5 FWFT FIFO with
// shared stimulus; queue models predict occupancy, flags, errors and read data.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] wr_data;

  logic [7:0] rd_data0;
  logic       rd_valid0, full0, empty0, af0, ae0, ov0, un0;
  logic [4:0] count0;

  logic [7:0] rd_data1;
  logic       rd_valid1, full1, empty1, af1, ae1, ov1, un1;
  logic [2:0] count1;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  // Reference state: FIFO contents, pending registered-read results, error flags.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp0[$];
  bit mov0, mun0, mov1, mun1;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ov0), .underflow(un0), .clr_err(clr_err)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ov1), .underflow(un1), .clr_err(clr_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: advances at each active edge from the inputs applied before it.
  always @(posedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete(); exp0.delete();
      mov0 = 0; mun0 = 0; mov1 = 0; mun1 = 0;
    end else begin
      mov0 = (mov0 && !clr_err) || (wr_en && q0.size() == 16);
      mun0 = (mun0 && !clr_err) || (rd_en && q0.size() == 0);
      mov1 = (mov1 && !clr_err) || (wr_en && q1.size() == 5);
      mun1 = (mun1 && !clr_err) || (rd_en && q1.size() == 0);
      begin
        bit w0, r0, w1, r1;
        w0 = wr_en && q0.size() < 16;
        r0 = rd_en && q0.size() > 0;
        w1 = wr_en && q1.size() < 5;
        r1 = rd_en && q1.size() > 0;
        if (r0) exp0.push_back(q0.pop_front());
        if (w0) q0.push_back(wr_data);
        if (r1) void'(q1.pop_front());
        if (w1) q1.push_back(wr_data);
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("std_count", count0, q0.size());
      chk("std_full", full0, q0.size() == 16);
      chk("std_empty", empty0, q0.size() == 0);
      chk("std_almost_full", af0, q0.size() >= 14);
      chk("std_almost_empty", ae0, q0.size() <= 2);
      chk("std_overflow", ov0, mov0);
      chk("std_underflow", un0, mun0);
      chk("std_rd_valid", rd_valid0, exp0.size() != 0);
      if (exp0.size() != 0) begin
        logic [7:0] e;
        e = exp0.pop_front();
        if (rd_valid0) chk("std_rd_data", rd_data0, e);
      end

      chk("fwft_count", count1, q1.size());
      chk("fwft_full", full1, q1.size() == 5);
      chk("fwft_empty", empty1, q1.size() == 0);
      chk("fwft_almost_full", af1, q1.size() >= 4);
      chk("fwft_almost_empty", ae1, q1.size() <= 1);
      chk("fwft_overflow", ov1, mov1);
      chk("fwft_underflow", un1, mun1);
      chk("fwft_rd_valid", rd_valid1, q1.size() != 0);
      if (q1.size() != 0 && rd_valid1) chk("fwft_rd_data", rd_data1, q1[0]);
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit c);
    wr_en = w; rd_en = r; wr_data = d; clr_err = c;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_rd_data", rd_data0, 0);
    checking = 1'b1;
    rst = 1'b0;

    $display("phase: fill 16 then drain 16");
    for (int i = 1; i <= 16; i++) cyc(1, 0, 8'(i), 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);

    $display("phase: overflow, clear, underflow");
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'($urandom), 0);
    cyc(1, 0, 8'hAA, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 1, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    $display("phase: simultaneous read/write at count 4, full and empty");
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h40 + i), 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 8'(8'h50 + i), 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h60 + i), 0);
    cyc(1, 1, 8'hEE, 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 8'h00, 0);
    cyc(1, 1, 8'h77, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);

    $display("phase: FWFT single word");
    cyc(1, 0, 8'h5C, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);

    $display("phase: reset mid-burst");
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'(8'h90 + i), 0);
    rst = 1'b1;
    cyc(1, 0, 8'h99, 0);
    rst = 1'b0;
    cyc(1, 0, 8'h3C, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);

    $display("phase: random traffic");
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      wp = ((i / 200) % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      rst = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
          8'($urandom), $urandom_range(0, 15) == 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
